// File: rtl/stage_writeback.sv
// Writeback stage: vector data memory plus the select mux feeding the register file.
// Optional macro WB_WRITE_FORWARD_EN forwards writeData on select 0 during a write.
module stage_writeback #(
    parameter int vecSize      = 4,
    parameter int registerSize = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    writeEnable,
    input  logic [1:0]                              writeRegFrom,
    input  logic [registerSize-1:0]                 address,
    input  logic [registerSize-1:0]                 imm,
    input  logic [vecSize-1:0][registerSize-1:0]    writeData,
    input  logic [vecSize-1:0][registerSize-1:0]    aluResult,
    output logic [vecSize-1:0][registerSize-1:0]    writeBackData
);

    localparam int Depth = 2 ** registerSize;

    typedef logic [vecSize-1:0][registerSize-1:0] vec_t;

    vec_t [Depth-1:0] mem_q;
    vec_t [Depth-1:0] mem_d;
    vec_t             read_data;

    always_comb begin
        mem_d = mem_q;
        if (writeEnable) begin
            mem_d[address] = writeData;
        end
    end

    // Reset wipes every entry and also masks any write pending at that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
`ifdef WB_WRITE_FORWARD_EN
        if (writeEnable && !reset) begin
            read_data = writeData;
        end else begin
            read_data = mem_q[address];
        end
`else
        read_data = mem_q[address];
`endif
    end

    always_comb begin
        writeBackData = '0;
        case (writeRegFrom)
            2'd0:    writeBackData = read_data;
            2'd1:    writeBackData = aluResult;
            2'd2:    writeBackData = {vecSize{imm}};
            2'd3:    writeBackData = '0;
            default: writeBackData = '0;
        endcase
    end

endmodule

// File: tb/tb_stage_writeback.sv
// Self-checking bench for stage_writeback: expected vectors are queued as stimulus
// is applied and popped for comparison once the combinational output settles.
module tb_stage_writeback;

    logic             clk;
    logic             reset;
    logic             we;
    logic [1:0]       sel;
    logic [7:0]       addr;
    logic [7:0]       imm;
    logic [3:0][7:0]  wd;
    logic [3:0][7:0]  alu;
    logic [3:0][7:0]  wbd;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    int          n_checks;
    int          n_fail;

    stage_writeback #(.vecSize(4), .registerSize(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .writeEnable  (we),
        .writeRegFrom (sel),
        .address      (addr),
        .imm          (imm),
        .writeData    (wd),
        .aluResult    (alu),
        .writeBackData(wbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL reset_held got %h want %h", wbd, exp);
        end
        #9;
        reset = 1'b0;
        foreach (exp_q[i]) ;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            addr = (k == 0) ? 8'd0 : 8'd255;
            sel  = 2'd0;
            exp_q.push_back(32'h0);
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (wbd !== exp) begin
                n_fail++;
                $display("FAIL reset_addr%0d got %h want %h", addr, wbd, exp);
            end
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        we = 1'b1; addr = 8'd4; wd = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b1; addr = 8'd255; wd = 32'h01020304;
        @(negedge clk);
        we = 1'b0; wd = 32'h0;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h01020304);
        for (int k = 0; k < 3; k++) begin
            addr = (k == 0) ? 8'd4 : (k == 1) ? 8'd5 : 8'd255;
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (wbd !== exp) begin
                n_fail++;
                $display("FAIL write_rd%0d got %h want %h", addr, wbd, exp);
            end
        end
        n_checks++;
        if (wbd[0] !== 8'h04) begin
            n_fail++;
            $display("FAIL lane0 got %h want %h", wbd[0], 8'h04);
        end
    endtask

    task automatic test_imm();
        @(negedge clk);
        imm = 8'hFE; sel = 2'd2; addr = 8'd4;
        exp_q.push_back(32'hFEFEFEFE);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL imm got %h want %h", wbd, exp);
        end
        imm = 8'h3C;
        exp_q.push_back(32'h3C3C3C3C);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL imm2 got %h want %h", wbd, exp);
        end
    endtask

    task automatic test_alu();
        @(negedge clk);
        alu = 32'hCAFEBABE; sel = 2'd1;
        exp_q.push_back(32'hCAFEBABE);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL alu got %h want %h", wbd, exp);
        end
        sel = 2'd3;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL zero_sel got %h want %h", wbd, exp);
        end
    endtask

    task automatic test_overwrite();
        @(negedge clk);
        sel = 2'd0; addr = 8'd4; we = 1'b1; wd = 32'h11223344;
        @(negedge clk);
        we = 1'b0; wd = 32'hAAAAAAAA;
        exp_q.push_back(32'h11223344);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL overwrite got %h want %h", wbd, exp);
        end
        repeat (3) @(negedge clk);
        exp_q.push_back(32'h11223344);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL hold got %h want %h", wbd, exp);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL async_rst got %h want %h", wbd, exp);
        end
        we = 1'b1; wd = 32'h55667788; addr = 8'd9;
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        reset = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL rst_discard got %h want %h", wbd, exp);
        end
        @(negedge clk);
        we = 1'b1; wd = 32'h0BADF00D; addr = 8'd7; sel = 2'd0;
`ifdef WB_WRITE_FORWARD_EN
        exp_q.push_back(32'h0BADF00D);
`else
        exp_q.push_back(32'h0);
`endif
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL pre_edge got %h want %h", wbd, exp);
        end
        @(negedge clk);
        we = 1'b0;
        exp_q.push_back(32'h0BADF00D);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (wbd !== exp) begin
            n_fail++;
            $display("FAIL post_edge got %h want %h", wbd, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a[8];
        logic [31:0] d[8];
        for (int k = 0; k < 8; k++) begin
            a[k] = 8'(k * 29 + 11);
            d[k] = $urandom;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            we = 1'b1; addr = a[k]; wd = d[k];
            exp_q.push_back(d[k]);
        end
        @(negedge clk);
        we = 1'b0; sel = 2'd0;
        for (int k = 0; k < 8; k++) begin
            addr = a[k];
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (wbd !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d got %h want %h", addr, wbd, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        we    = 1'b0;
        sel   = 2'd0;
        addr  = 8'd0;
        imm   = 8'd0;
        wd    = '0;
        alu   = '0;
        test_reset();
        test_write();
        test_imm();
        test_alu();
        test_overwrite();
        test_async_reset();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover got %0d want %0d", exp_q.size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got %0t want %0d", $time, 20000);
        $fatal(1, "timeout");
    end

endmodule
